// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory bus between the fetch sequencer and memory
//
// Purpose: groups the memory-port request/response signals of the fetch
// sequencer so the core and the memory model connect through one bundle.
// Signals:
//   mem_req       sequencer -> memory  access request valid
//   mem_rw        sequencer -> memory  1 = read, 0 = write
//   mem_addr      sequencer -> memory  access address
//   mem_data_out  sequencer -> memory  write data (0 outside a store)
//   mem_data_in   memory -> sequencer  read data
//   mem_ready     memory -> sequencer  current access completes this cycle
// Modports: master (sequencer side), slave (memory side).

interface fetch_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_rw,
    output mem_addr,
    output mem_data_out,
    input  mem_data_in,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_rw,
    input  mem_addr,
    input  mem_data_out,
    output mem_data_in,
    output mem_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/sequencing unit with wait states, store phase, branch and bus timeout
//
// Purpose: owns the program counter, the instruction register and the memory
// port. Each instruction walks FETCH -> EXEC -> (STORE) -> ADVANCE -> FETCH.
// Memory accesses may stall on mem_ready; a stall that lasts WAIT_MAX cycles
// parks the unit in FAULT until reset.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   mem            memory bus (master side): req/rw/addr/data_out out,
//                  data_in/ready in
//   instr          instruction register
//   instr_valid    high while in EXEC
//   exec_done      datapath finished the current instruction
//   store_req      sampled with exec_done: instruction needs a memory write
//   store_addr     sampled with exec_done: write address
//   store_data     sampled with exec_done: write data
//   branch_taken   sampled with exec_done: redirect the PC
//   branch_target  sampled with exec_done: redirect address
//   pc             current program counter
//   state          FETCH=0 EXEC=1 STORE=2 ADVANCE=3 FAULT=4
//   fault          sticky bus-timeout indicator

module fetch_sequencer #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,

  fetch_sequencer_if.master  mem,

  output logic [DATA_W-1:0]  instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               store_req,
  input  logic [ADDR_W-1:0]  store_addr,
  input  logic [DATA_W-1:0]  store_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,

  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         state,
  output logic               fault
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXEC    = 3'd1,
    ST_STORE   = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // The counter only ever has to hold 0..WAIT_MAX-1: the cycle that would
  // take it to WAIT_MAX is the cycle that leaves for FAULT instead.
  localparam int unsigned WCW         = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam int unsigned WAIT_LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LAST_I);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc_q;
  logic [ADDR_W-1:0] store_addr_q;
  logic [DATA_W-1:0] store_data_q;
  logic [DATA_W-1:0] instr_q;
  logic [WCW-1:0]    wait_q;
  logic              fault_q;

  logic              timeout;
  logic              bus_phase;

  // Timeout fires on the WAIT_MAX-th consecutive unready cycle. mem_ready is
  // checked first in the next-state logic, so a completion on that same cycle
  // still wins.
  assign timeout   = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);
  assign bus_phase = (state_q == ST_FETCH) || (state_q == ST_STORE);

  // Next-state and output decode
  always_comb begin
    state_d          = state_q;
    mem.mem_req      = 1'b0;
    mem.mem_rw       = 1'b1;
    mem.mem_addr     = pc_q;
    mem.mem_data_out = '0;
    instr_valid      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          state_d = ST_EXEC;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end

      ST_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          state_d = store_req ? ST_STORE : ST_ADVANCE;
        end
      end

      ST_STORE: begin
        mem.mem_req      = 1'b1;
        mem.mem_rw       = 1'b0;
        mem.mem_addr     = store_addr_q;
        mem.mem_data_out = store_data_q;
        if (mem.mem_ready) begin
          state_d = ST_ADVANCE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end

      ST_ADVANCE: begin
        state_d = ST_FETCH;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, PC, instruction, latched store/branch results, wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      next_pc_q    <= '0;
      store_addr_q <= '0;
      store_data_q <= '0;
      instr_q      <= '0;
      wait_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (bus_phase && !mem.mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end

      // Zero is a legal instruction word, so the load is unconditional on data.
      if (state_q == ST_FETCH && mem.mem_ready) begin
        instr_q <= mem.mem_data_in;
      end

      // The redirect is only computed here and applied in ADVANCE, so a
      // taken branch that also stores lets the store finish first.
      if (state_q == ST_EXEC && exec_done) begin
        next_pc_q <= branch_taken ? branch_target : pc_q + STEP;
        if (store_req) begin
          store_addr_q <= store_addr;
          store_data_q <= store_data;
        end
      end

      if (state_q == ST_ADVANCE) begin
        pc_q <= next_pc_q;
      end

      if (state_d == ST_FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        store_req;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: architectural PC of the instruction currently being fetched.
  logic [31:0] model_pc;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fetch_sequencer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  fetch_sequencer #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .PC_STEP (1),
    .RESET_PC(32'h0),
    .WAIT_MAX(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem          (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .store_req    (store_req),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .state        (state),
    .fault        (fault)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    exec_done       = 1'b0;
    store_req       = 1'b0;
    store_addr      = '0;
    store_data      = '0;
    branch_taken    = 1'b0;
    branch_target   = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_pc = 32'h0;
  endtask

  // Plays memory and datapath for one instruction starting in FETCH, checking
  // every cycle against the phase the model expects.
  task automatic do_instr(input logic [31:0] data, input int fwait, input int ewait,
                          input logic st, input int swait, input logic [31:0] sa,
                          input logic [31:0] sd, input logic br, input logic [31:0] bt);
    logic [31:0] exp_next;
    exp_next = br ? bt : model_pc + 32'd1;
    for (int i = 0; i <= fwait; i++) begin
      checks++;
      if (state !== 3'd0 || bus.mem_req !== 1'b1 || bus.mem_rw !== 1'b1 ||
          bus.mem_addr !== model_pc || bus.mem_data_out !== 32'h0) begin
        errors++;
        $display("FAIL fetch_phase state=%0d req=%b rw=%b addr=%h dout=%h expected state=0 req=1 rw=1 addr=%h dout=0",
                 state, bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_data_out, model_pc);
      end
      bus.mem_ready   = (i == fwait);
      bus.mem_data_in = (i == fwait) ? data : $urandom;
      step();
    end
    bus.mem_ready = 1'b0;
    for (int j = 0; j <= ewait; j++) begin
      checks++;
      if (state !== 3'd1 || instr_valid !== 1'b1 || instr !== data || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL exec_phase state=%0d valid=%b instr=%h req=%b expected state=1 valid=1 instr=%h req=0",
                 state, instr_valid, instr, bus.mem_req, data);
      end
      exec_done = (j == ewait);
      if (j == ewait) begin
        store_req = st; store_addr = sa; store_data = sd;
        branch_taken = br; branch_target = bt;
      end else begin
        store_req = 1'($urandom_range(1, 0)); store_addr = $urandom; store_data = $urandom;
        branch_taken = 1'($urandom_range(1, 0)); branch_target = $urandom;
      end
      bus.mem_ready = 1'($urandom_range(1, 0));
      step();
    end
    idle_inputs();
    if (st) begin
      for (int k = 0; k <= swait; k++) begin
        checks++;
        if (state !== 3'd2 || bus.mem_req !== 1'b1 || bus.mem_rw !== 1'b0 ||
            bus.mem_addr !== sa || bus.mem_data_out !== sd) begin
          errors++;
          $display("FAIL store_phase state=%0d req=%b rw=%b addr=%h dout=%h expected state=2 req=1 rw=0 addr=%h dout=%h",
                   state, bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_data_out, sa, sd);
        end
        bus.mem_ready = (k == swait);
        step();
      end
    end
    checks++;
    if (state !== 3'd3 || bus.mem_req !== 1'b0 || pc !== model_pc || bus.mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL advance_phase state=%0d req=%b pc=%h expected state=3 req=0 pc=%h",
               state, bus.mem_req, pc, model_pc);
    end
    bus.mem_ready = 1'($urandom_range(1, 0));
    step();
    bus.mem_ready = 1'b0;
    checks++;
    if (state !== 3'd0 || pc !== exp_next || bus.mem_addr !== exp_next || fault !== 1'b0) begin
      errors++;
      $display("FAIL next_pc state=%0d pc=%h addr=%h fault=%b expected state=0 pc=%h addr=%h fault=0",
               state, pc, bus.mem_addr, fault, exp_next, exp_next);
    end
    model_pc = exp_next;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'hA5A5_A5A5;
    exec_done = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    exec_done = 1'b0;
    model_pc = 32'h0;
    checks++;
    if (state !== 3'd0 || pc !== 32'h0 || instr !== 32'h0 || fault !== 1'b0 ||
        bus.mem_req !== 1'b1 || bus.mem_rw !== 1'b1 || bus.mem_addr !== 32'h0 ||
        bus.mem_data_out !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state state=%0d pc=%h instr=%h fault=%b req=%b rw=%b addr=%h valid=%b expected 0/0/0/0/1/1/0/0",
               state, pc, instr, fault, bus.mem_req, bus.mem_rw, bus.mem_addr, instr_valid);
    end
  endtask

  task automatic test_sequential();
    int start [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start[i] = cyc;
      checks++;
      if (bus.mem_addr !== 32'(i)) begin
        errors++;
        $display("FAIL seq_addr got=%h expected=%h", bus.mem_addr, 32'(i));
      end
      do_instr($urandom, 0, 0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (start[i] - start[i-1] !== 3) begin
        errors++;
        $display("FAIL seq_period got=%0d expected=3", start[i] - start[i-1]);
      end
    end
  endtask

  task automatic test_zero_fetch();
    do_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0);
    do_instr(32'h0, 1, 0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    do_instr($urandom, 0, 1, 1'b0, 0, 32'h0, 32'h0, 1'b1, 32'h40);
    checks++;
    if (bus.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL branch_addr got=%h expected=00000040", bus.mem_addr);
    end
  endtask

  task automatic test_store();
    logic [31:0] old_pc;
    int t0;
    old_pc = model_pc;
    t0 = cyc;
    do_instr($urandom, 0, 0, 1'b1, 2, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    checks++;
    if (bus.mem_addr !== old_pc + 32'd1 || cyc - t0 !== 6) begin
      errors++;
      $display("FAIL store_after addr=%h cycles=%0d expected addr=%h cycles=6",
               bus.mem_addr, cyc - t0, old_pc + 32'd1);
    end
    do_instr($urandom, 0, 0, 1'b1, 0, $urandom, $urandom, 1'b1, 32'h200);
  endtask

  task automatic test_wait_boundary();
    do_instr($urandom, 3, 0, 1'b1, 3, $urandom, $urandom, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    do_instr($urandom, 0, 0, 1'b0, 0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    do_instr($urandom, 0, 0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap got=%h expected=00000000", pc);
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_early cycle=%0d state=%0d fault=%b expected state=0 fault=0", i, state, fault);
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== 3'd4 || fault !== 1'b1 || bus.mem_req !== 1'b0 || pc !== 32'h0) begin
        errors++;
        $display("FAIL fault_hold cycle=%0d state=%0d fault=%b req=%b pc=%h expected 4/1/0/0",
                 i, state, fault, bus.mem_req, pc);
      end
      bus.mem_ready = 1'($urandom_range(1, 0));
      exec_done = 1'($urandom_range(1, 0));
      step();
    end
    do_reset();
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL fault_reset state=%0d fault=%b pc=%h expected 0/0/0", state, fault, pc);
    end
  endtask

  task automatic test_reset_in_store();
    do_instr($urandom, 0, 0, 1'b0, 0, 32'h0, 32'h0, 1'b1, 32'h80);
    bus.mem_ready = 1'b1;
    bus.mem_data_in = $urandom;
    step();
    idle_inputs();
    exec_done = 1'b1; store_req = 1'b1; store_addr = 32'h44; store_data = 32'h1234_5678;
    step();
    idle_inputs();
    checks++;
    if (state !== 3'd2 || bus.mem_rw !== 1'b0) begin
      errors++;
      $display("FAIL store_entry state=%0d rw=%b expected state=2 rw=0", state, bus.mem_rw);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_pc = 32'h0;
    checks++;
    if (state !== 3'd0 || bus.mem_rw !== 1'b1 || pc !== 32'h0 || bus.mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL store_reset state=%0d rw=%b pc=%h dout=%h expected 0/1/0/0",
               state, bus.mem_rw, pc, bus.mem_data_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      do_instr($urandom, $urandom_range(3, 0), $urandom_range(2, 0),
               1'($urandom_range(1, 0)), $urandom_range(3, 0), $urandom, $urandom,
               1'($urandom_range(1, 0)), $urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_zero_fetch();
    test_branch();
    test_store();
    test_wait_boundary();
    test_wrap();
    test_random();
    test_fault();
    test_reset_in_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
